// File: rtl/isa_io_slot_bridge.sv
// isa_io_slot_bridge
//   Decodes a 16-port I/O window on the chipset's external I/O channel. Each
//   qualified strobe becomes one req/ack transaction to a slow peripheral.
//   io_channel_ready is held low while the peripheral works. On a read, the
//   captured data is returned on data_bus_ext together with a drive-enable.
//
// Optional feature (macro ISA_BRIDGE_TIMEOUT_EN):
//   Aborts WAIT_ACK after TIMEOUT_CYCLES cycles. An aborted read returns
//   IDLE_READ_VALUE. An aborted write is dropped.
//
// Ports
//   clock, reset                 system clock, synchronous active-high reset
//   address[19:0]                chipset address; only [9:0] are decoded
//   data_bus[7:0]                chipset write data
//   io_read_n, io_write_n        I/O strobes, active low
//   address_enable_n             1 = CPU cycle (decode allowed), 0 = DMA
//   data_bus_ext[7:0]            read data toward the chipset
//   data_bus_ext_drive           1 = data_bus_ext valid
//   io_channel_ready             0 = insert wait states
//   dev_request, dev_write       peripheral request / direction
//   dev_address[3:0]             port offset within the window
//   dev_write_data[7:0]          peripheral write data
//   dev_ready, dev_read_data     peripheral acknowledge and read data
module isa_io_slot_bridge #(
  parameter logic [9:0]  BASE_ADDR       = 10'h300,
  parameter logic [7:0]  IDLE_READ_VALUE = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  data_bus,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        address_enable_n,
  output logic [7:0]  data_bus_ext,
  output logic        data_bus_ext_drive,
  output logic        io_channel_ready,
  output logic        dev_request,
  output logic        dev_write,
  output logic [3:0]  dev_address,
  output logic [7:0]  dev_write_data,
  input  logic        dev_ready,
  input  logic [7:0]  dev_read_data
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQUEST  = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        dev_write_q, dev_write_d;
  logic [3:0]  dev_address_q, dev_address_d;
  logic [7:0]  dev_write_data_q, dev_write_data_d;
  logic [7:0]  capture_q, capture_d;
  // Set once the strobe has been seen inactive while the peripheral is busy.
  // Such a transaction finishes straight into IDLE, and its read data is dropped.
  logic        strobe_gone_q, strobe_gone_d;

  logic hit, strobe_active, ended;

  // Both strobes low at once is treated as a malformed cycle, not a hit.
  assign hit           = address_enable_n & (address[9:4] == BASE_ADDR[9:4]) &
                         (io_read_n ^ io_write_n);
  assign strobe_active = ~io_read_n | ~io_write_n;
  assign ended         = strobe_gone_q | ~strobe_active;

`ifdef ISA_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       unused_addr_hi;
  assign unused_addr_hi = ^address[19:10];
`else
  logic unused_cfg;
  assign unused_cfg = ^{address[19:10], IDLE_READ_VALUE, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d          = state_q;
    dev_write_d      = dev_write_q;
    dev_address_d    = dev_address_q;
    dev_write_data_d = dev_write_data_q;
    capture_d        = capture_q;
    strobe_gone_d    = strobe_gone_q;
`ifdef ISA_BRIDGE_TIMEOUT_EN
    cnt_d            = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          dev_write_d      = ~io_write_n;
          dev_address_d    = address[3:0];
          dev_write_data_d = data_bus;
          strobe_gone_d    = 1'b0;
          state_d          = S_REQUEST;
        end
      end
      S_REQUEST: begin
        // dev_ready is deliberately ignored here. Every transaction makes at
        // least one WAIT_ACK pass, even when dev_ready is held high as a level.
        if (!strobe_active) strobe_gone_d = 1'b1;
`ifdef ISA_BRIDGE_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!strobe_active) strobe_gone_d = 1'b1;
        if (dev_ready) begin
          if (!dev_write_q && !ended) capture_d = dev_read_data;
          state_d = ended ? S_IDLE : S_HOLD;
        end
`ifdef ISA_BRIDGE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          if (!dev_write_q) capture_d = IDLE_READ_VALUE;
          state_d = ended ? S_IDLE : S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_HOLD: begin
        // HOLD is left only once the strobe is seen high. A held strobe
        // therefore can never start a second transaction.
        if (!strobe_active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      dev_write_q      <= 1'b0;
      dev_address_q    <= 4'h0;
      dev_write_data_q <= 8'h00;
      capture_q        <= 8'h00;
      strobe_gone_q    <= 1'b0;
`ifdef ISA_BRIDGE_TIMEOUT_EN
      cnt_q            <= 8'd0;
`endif
    end else begin
      state_q          <= state_d;
      dev_write_q      <= dev_write_d;
      dev_address_q    <= dev_address_d;
      dev_write_data_q <= dev_write_data_d;
      capture_q        <= capture_d;
      strobe_gone_q    <= strobe_gone_d;
`ifdef ISA_BRIDGE_TIMEOUT_EN
      cnt_q            <= cnt_d;
`endif
    end
  end

  // Ready drops in the same cycle the strobe first qualifies in IDLE.
  assign io_channel_ready   = ~(((state_q == S_IDLE) & hit) |
                                (state_q == S_REQUEST) | (state_q == S_WAIT_ACK));
  assign dev_request        = (state_q == S_REQUEST) | (state_q == S_WAIT_ACK);
  assign dev_write          = dev_write_q;
  assign dev_address        = dev_address_q;
  assign dev_write_data     = dev_write_data_q;
  assign data_bus_ext_drive = (state_q == S_HOLD) & ~dev_write_q & ~io_read_n;
  assign data_bus_ext       = data_bus_ext_drive ? capture_q : 8'h00;

endmodule

// File: tb/tb_isa_io_slot_bridge.sv
module tb_isa_io_slot_bridge;

  localparam logic [9:0] BASE = 10'h300;
  localparam int         TO   = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [7:0]  data_bus;
  logic        io_read_n, io_write_n, address_enable_n;
  logic [7:0]  data_bus_ext;
  logic        data_bus_ext_drive, io_channel_ready;
  logic        dev_request, dev_write;
  logic [3:0]  dev_address;
  logic [7:0]  dev_write_data;
  logic        dev_ready;
  logic [7:0]  dev_read_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  isa_io_slot_bridge #(
    .BASE_ADDR(BASE), .IDLE_READ_VALUE(8'hFF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .data_bus(data_bus),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .address_enable_n(address_enable_n), .data_bus_ext(data_bus_ext),
    .data_bus_ext_drive(data_bus_ext_drive), .io_channel_ready(io_channel_ready),
    .dev_request(dev_request), .dev_write(dev_write), .dev_address(dev_address),
    .dev_write_data(dev_write_data), .dev_ready(dev_ready),
    .dev_read_data(dev_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic idle_bus();
    io_read_n = 1'b1; io_write_n = 1'b1; address_enable_n = 1'b1;
    dev_ready = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rdy"}, io_channel_ready, 1);
    chk({tag, "_req"}, dev_request, 0);
    chk({tag, "_drv"}, data_bus_ext_drive, 0);
    chk({tag, "_ext"}, data_bus_ext, 0);
  endtask

  // One window hit, checked against the handshake rules. early: dev_ready
  // also high in the REQUEST cycle (must be ignored). d: extra WAIT_ACK
  // cycles before the ack. h: HOLD cycles with the strobe still low.
  // drop: strobe released in the first WAIT_ACK cycle.
  task automatic run_hit(input bit is_rd, input logic [3:0] off, input logic [7:0] wd,
                         input logic [7:0] rd, input bit early, input int d,
                         input int h, input bit drop);
    cyc();
    address = {10'($urandom), BASE[9:4], off};
    data_bus = wd; address_enable_n = 1'b1;
    io_read_n = ~is_rd; io_write_n = is_rd; dev_ready = 1'b0;
    #1;
    chk("hit_rdy0", io_channel_ready, 0);
    chk("hit_req0", dev_request, 0);
    cyc();
    dev_ready = early; dev_read_data = 8'($urandom);
    data_bus = 8'($urandom);
    #1;
    chk("req_req", dev_request, 1);
    chk("req_rdy", io_channel_ready, 0);
    chk("req_wr", dev_write, !is_rd);
    chk("req_addr", dev_address, off);
    chk("req_wd", dev_write_data, wd);
    for (int k = 0; k <= d; k++) begin
      cyc();
      dev_ready = (k == d);
      dev_read_data = (k == d) ? rd : 8'($urandom);
      if (drop && k == 0) begin io_read_n = 1'b1; io_write_n = 1'b1; end
      #1;
      chk("wait_req", dev_request, 1);
      chk("wait_rdy", io_channel_ready, 0);
    end
    if (!drop) begin
      for (int j = 0; j < h; j++) begin
        cyc();
        dev_ready = 1'($urandom); dev_read_data = 8'($urandom);
        #1;
        chk("hold_req", dev_request, 0);
        chk("hold_rdy", io_channel_ready, 1);
        chk("hold_drv", data_bus_ext_drive, is_rd);
        chk("hold_ext", data_bus_ext, is_rd ? rd : 8'h00);
      end
      cyc();
      io_read_n = 1'b1; io_write_n = 1'b1; dev_ready = 1'b0;
      #1;
      chk_quiet("rel");
    end else begin
      cyc();
      dev_ready = 1'b0;
    end
  endtask

  // A strobe that must not be decoded: no handshake, and ready stays high.
  task automatic run_miss(input logic [19:0] a, input bit rn, input bit wn,
                          input bit aen, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      address = a; io_read_n = rn; io_write_n = wn; address_enable_n = aen;
      data_bus = 8'($urandom); dev_ready = 1'($urandom);
      #1;
      chk_quiet("miss");
    end
    cyc();
    idle_bus();
    #1;
    chk_quiet("miss_rel");
  endtask

  function automatic logic [19:0] miss_addr();
    logic [5:0] hi;
    hi = 6'($urandom_range(0, 62));
    if (hi >= BASE[9:4]) hi = hi + 6'd1;
    return {10'($urandom), hi, 4'($urandom)};
  endfunction

  initial begin
    int cnt;
    reset = 1'b1; address = 20'h0; data_bus = 8'h0; dev_read_data = 8'h0;
    idle_bus();
    cyc(); cyc();
    #1;
    chk_quiet("rst");
    chk("rst_wr", dev_write, 0);
    chk("rst_addr", dev_address, 0);
    chk("rst_wd", dev_write_data, 0);
    cyc(); reset = 1'b0;

    // Directed write: the ack comes 2 cycles after the request rises.
    run_hit(1'b0, 4'h5, 8'hA5, 8'h00, 1'b0, 1, 2, 1'b0);
    // Directed read: the ack comes on the first WAIT_ACK cycle.
    run_hit(1'b1, 4'hF, 8'h00, 8'h3C, 1'b0, 0, 2, 1'b0);
    // Decode misses.
    run_miss(20'h00310, 1'b1, 1'b0, 1'b1, 3);
    run_miss(20'h00300, 1'b0, 1'b1, 1'b0, 3);
    run_miss(20'h00300, 1'b0, 1'b0, 1'b1, 3);
    // Held read strobe: exactly one request, then a fresh strobe re-issues.
    run_hit(1'b1, 4'h2, 8'h00, 8'h81, 1'b0, 0, 10, 1'b0);
    run_hit(1'b1, 4'h2, 8'h00, 8'h18, 1'b1, 0, 1, 1'b0);
    // Strobe drops mid-transaction: the next hit must be accepted immediately.
    run_hit(1'b1, 4'h7, 8'h00, 8'h55, 1'b0, 2, 1, 1'b1);
    run_hit(1'b0, 4'h8, 8'h99, 8'h00, 1'b0, 0, 1, 1'b0);

    // Reset in WAIT_ACK.
    cyc(); address = {10'h0, BASE}; io_read_n = 1'b0; dev_ready = 1'b0;
    cyc(); cyc();
    #1; chk("pre_rst_req", dev_request, 1);
    cyc(); reset = 1'b1; idle_bus();
    cyc(); reset = 1'b0;
    #1;
    chk_quiet("mid_rst");
    chk("mid_rst_addr", dev_address, 0);
    chk("mid_rst_wr", dev_write, 0);
    run_hit(1'b0, 4'hC, 8'h3E, 8'h00, 1'b0, 0, 1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: run_hit(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                         1'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                         ($urandom_range(0, 5) == 0));
        3: run_miss(miss_addr(), 1'($urandom), 1'b0, 1'b1, $urandom_range(1, 3));
        4: run_miss({10'($urandom), BASE[9:4], 4'($urandom)}, 1'($urandom), 1'b0,
                    1'b0, $urandom_range(1, 3));
        default: run_miss({10'($urandom), BASE[9:4], 4'($urandom)}, 1'b0, 1'b0,
                          1'b1, $urandom_range(1, 3));
      endcase
    end

    // Peripheral never acknowledges a read.
    cyc(); address = {10'h0, BASE[9:4], 4'h1}; io_read_n = 1'b0; dev_ready = 1'b0;
    cyc();
`ifdef ISA_BRIDGE_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < TO; i++) begin
      cyc(); #1;
      if (io_channel_ready !== 1'b0) cnt++;
    end
    chk("to_wait_rdy_hi_cycles", cnt, 0);
    cyc(); dev_ready = 1'b1;
    #1;
    chk("to_rdy", io_channel_ready, 1);
    chk("to_drv", data_bus_ext_drive, 1);
    chk("to_ext", data_bus_ext, 8'hFF);
    cyc(); dev_ready = 1'b0; dev_read_data = 8'h12;
    #1;
    chk("to_late_ext", data_bus_ext, 8'hFF);
    chk("to_late_req", dev_request, 0);
`else
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); #1;
      if (io_channel_ready !== 1'b0 || dev_request !== 1'b1) cnt++;
    end
    chk("nto_wait_cycles_bad", cnt, 0);
    cyc(); dev_ready = 1'b1; dev_read_data = 8'h6D;
    cyc(); dev_ready = 1'b0;
    #1;
    chk("nto_rdy", io_channel_ready, 1);
    chk("nto_ext", data_bus_ext, 8'h6D);
`endif
    cyc(); idle_bus();
    #1;
    chk_quiet("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
